riscv_instr_decoder: RTL and testbench



---
 rtl/riscv_instr_decoder_pkg.sv | 62 ++++++
 rtl/riscv_instr_decoder_decode_comb.sv | 150 +++++++++++++++
 rtl/riscv_instr_decoder.sv | 92 +++++++++
 tb/tb_riscv_instr_decoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_instr_decoder_pkg.sv
// rtl/riscv_instr_decoder_pkg.sv - shared RV32I instruction property types for the decoder
package riscv_instruction_properties;

  typedef enum logic [7:0] {
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU, SB, SH, SW,
    ADD, ADDI, NOP, SUB, SLL, SLLI, SLT, SLTI, SLTU, SLTIU,
    XOR, XORI, OR, ORI, AND, ANDI, SRL, SRLI, SRA, SRAI,
    FENCE, FENCE_I, ECALL, EBREAK,
    CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI
  } riscv_instr_name_t;

  typedef enum logic [2:0] {
    J_FORMAT, U_FORMAT, I_FORMAT, I_FORMAT_SHIFT, B_FORMAT, R_FORMAT, S_FORMAT
  } riscv_instr_format_t;

  typedef enum logic [4:0] {
    ZERO, RA, SP, GP, TP, T0, T1, T2, S0, S1,
    A0, A1, A2, A3, A4, A5, A6, A7,
    S2, S3, S4, S5, S6, S7, S8, S9, S10, S11,
    T3, T4, T5, T6
  } riscv_reg_t;

  localparam logic [15:0] CAT_LOAD    = 16'h0001;
  localparam logic [15:0] CAT_STORE   = 16'h0002;
  localparam logic [15:0] CAT_SHIFT   = 16'h0004;
  localparam logic [15:0] CAT_ARITH   = 16'h0008;
  localparam logic [15:0] CAT_LOGICAL = 16'h0010;
  localparam logic [15:0] CAT_COMPARE = 16'h0020;
  localparam logic [15:0] CAT_BRANCH  = 16'h0040;
  localparam logic [15:0] CAT_JUMP    = 16'h0080;
  localparam logic [15:0] CAT_SYNCH   = 16'h0100;
  localparam logic [15:0] CAT_SYSTEM  = 16'h0200;
  localparam logic [15:0] CAT_CSR     = 16'h0800;
  localparam logic [15:0] CAT_TRAP    = 16'h2000;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    riscv_instr_name_t   name;
    riscv_instr_format_t format;
    logic [15:0]         category;
    riscv_reg_t          rd;
    riscv_reg_t          rs1;
    riscv_reg_t          rs2;
    logic [31:0]         imm;
    logic [11:0]         csr;
    logic                illegal;
  } riscv_decoded_instr_t;

endpackage

// File: rtl/riscv_instr_decoder_decode_comb.sv
// rtl/riscv_instr_decoder_decode_comb.sv - combinational RV32I word-to-fields decode
module riscv_instr_decode_comb
  import riscv_instruction_properties::*;
#(
  parameter bit EN_NOP_ALIAS = 1'b1
) (
  input  logic [31:0]          instr,
  output riscv_decoded_instr_t dec
);

  logic [6:0]  opcode;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic        legal;
  riscv_reg_t  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign rd     = riscv_reg_t'(instr[11:7]);
  assign rs1    = riscv_reg_t'(instr[19:15]);
  assign rs2    = riscv_reg_t'(instr[24:20]);
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    dec   = '0;
    legal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        legal = 1'b1;
        dec.name = (opcode == OPC_LUI) ? LUI : AUIPC;
        dec.format = U_FORMAT; dec.rd = rd; dec.imm = imm_u; dec.category = CAT_ARITH;
      end
      OPC_JAL: begin
        legal = 1'b1;
        dec.name = JAL; dec.format = J_FORMAT; dec.rd = rd; dec.imm = imm_j; dec.category = CAT_JUMP;
      end
      OPC_JALR: begin
        legal = (f3 == 3'b000);
        dec.name = JALR; dec.format = I_FORMAT; dec.rd = rd; dec.rs1 = rs1;
        dec.imm = imm_i; dec.category = CAT_JUMP;
      end
      OPC_BRANCH: begin
        legal = (f3[2:1] != 2'b01);
        dec.format = B_FORMAT; dec.rs1 = rs1; dec.rs2 = rs2; dec.imm = imm_b; dec.category = CAT_BRANCH;
        case (f3)
          3'b000:  dec.name = BEQ;
          3'b001:  dec.name = BNE;
          3'b100:  dec.name = BLT;
          3'b101:  dec.name = BGE;
          3'b110:  dec.name = BLTU;
          default: dec.name = BGEU;
        endcase
      end
      OPC_LOAD: begin
        legal = (f3 != 3'b011) && (f3[2:1] != 2'b11);
        dec.format = I_FORMAT; dec.rd = rd; dec.rs1 = rs1; dec.imm = imm_i; dec.category = CAT_LOAD;
        case (f3)
          3'b000:  dec.name = LB;
          3'b001:  dec.name = LH;
          3'b010:  dec.name = LW;
          3'b100:  dec.name = LBU;
          default: dec.name = LHU;
        endcase
      end
      OPC_STORE: begin
        legal = (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
        dec.format = S_FORMAT; dec.rs1 = rs1; dec.rs2 = rs2; dec.imm = imm_s; dec.category = CAT_STORE;
        dec.name = (f3[1:0] == 2'b00) ? SB : (f3[1:0] == 2'b01) ? SH : SW;
      end
      OPC_OPIMM: begin
        legal = 1'b1;
        dec.format = I_FORMAT; dec.rd = rd; dec.rs1 = rs1; dec.imm = imm_i;
        case (f3)
          3'b000: begin
            dec.name = (EN_NOP_ALIAS && instr == 32'h0000_0013) ? NOP : ADDI;
            dec.category = CAT_ARITH;
          end
          3'b010:  begin dec.name = SLTI;  dec.category = CAT_COMPARE; end
          3'b011:  begin dec.name = SLTIU; dec.category = CAT_COMPARE; end
          3'b100:  begin dec.name = XORI;  dec.category = CAT_LOGICAL; end
          3'b110:  begin dec.name = ORI;   dec.category = CAT_LOGICAL; end
          3'b111:  begin dec.name = ANDI;  dec.category = CAT_LOGICAL; end
          default: begin
            // shifts: funct7 selects logical/arithmetic, shamt is unsigned
            legal = (f7 == 7'b0000000) || (f3 == 3'b101 && f7 == 7'b0100000);
            dec.name = (f3 == 3'b001) ? SLLI : (f7[5] ? SRAI : SRLI);
            dec.format = I_FORMAT_SHIFT; dec.imm = {27'b0, instr[24:20]}; dec.category = CAT_SHIFT;
          end
        endcase
      end
      OPC_OP: begin
        dec.format = R_FORMAT; dec.rd = rd; dec.rs1 = rs1; dec.rs2 = rs2;
        if (f7 == 7'b0000000) begin
          legal = 1'b1;
          case (f3)
            3'b000:  begin dec.name = ADD;  dec.category = CAT_ARITH;   end
            3'b001:  begin dec.name = SLL;  dec.category = CAT_SHIFT;   end
            3'b010:  begin dec.name = SLT;  dec.category = CAT_COMPARE; end
            3'b011:  begin dec.name = SLTU; dec.category = CAT_COMPARE; end
            3'b100:  begin dec.name = XOR;  dec.category = CAT_LOGICAL; end
            3'b101:  begin dec.name = SRL;  dec.category = CAT_SHIFT;   end
            3'b110:  begin dec.name = OR;   dec.category = CAT_LOGICAL; end
            default: begin dec.name = AND;  dec.category = CAT_LOGICAL; end
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          legal = 1'b1; dec.name = SUB; dec.category = CAT_ARITH;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          legal = 1'b1; dec.name = SRA; dec.category = CAT_SHIFT;
        end
      end
      OPC_MISC_MEM: begin
        legal = (f3[2:1] == 2'b00);
        dec.name = f3[0] ? FENCE_I : FENCE;
        dec.format = I_FORMAT; dec.rd = rd; dec.rs1 = rs1; dec.imm = imm_i; dec.category = CAT_SYNCH;
      end
      OPC_SYSTEM: begin
        dec.format = I_FORMAT;
        if (f3 == 3'b000) begin
          legal = (instr == 32'h0000_0073) || (instr == 32'h0010_0073);
          dec.name = instr[20] ? EBREAK : ECALL;
          dec.category = CAT_SYSTEM | CAT_TRAP;
        end else if (f3 != 3'b100) begin
          legal = 1'b1;
          dec.rd = rd; dec.csr = instr[31:20]; dec.category = CAT_CSR;
          if (f3[2]) begin
            dec.name = (f3[1:0] == 2'b01) ? CSRRWI : (f3[1:0] == 2'b10) ? CSRRSI : CSRRCI;
            dec.imm = {27'b0, instr[19:15]};
          end else begin
            dec.name = (f3[1:0] == 2'b01) ? CSRRW : (f3[1:0] == 2'b10) ? CSRRS : CSRRC;
            dec.rs1 = rs1;
          end
        end
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.name    = NOP;
      dec.format  = I_FORMAT;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/riscv_instr_decoder.sv
// rtl/riscv_instr_decoder.sv - two-stage RV32I decoder with stream handshake, flush and counters
module riscv_instr_decoder
  import riscv_instruction_properties::*;
#(
  parameter int CNT_W        = 32,
  parameter bit EN_NOP_ALIAS = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output riscv_instr_name_t   out_name,
  output riscv_instr_format_t out_format,
  output logic [15:0]         out_category,
  output riscv_reg_t          out_rd,
  output riscv_reg_t          out_rs1,
  output riscv_reg_t          out_rs2,
  output logic [31:0]         out_imm,
  output logic [11:0]         out_csr,
  output logic                out_illegal,
  output logic [31:0]         out_raw,
  output logic [CNT_W-1:0]    decoded_cnt,
  output logic [CNT_W-1:0]    illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic                 s1_valid, s2_valid;
  logic                 s1_adv, s2_adv;
  logic [31:0]          s1_instr, s2_raw;
  riscv_decoded_instr_t dec, s2_data;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = rst_n && s1_adv && !flush;

  riscv_instr_decode_comb #(.EN_NOP_ALIAS(EN_NOP_ALIAS)) u_decode (
    .instr (s1_instr),
    .dec   (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      s1_instr    <= '0;
      s2_raw      <= '0;
      s2_data     <= '0;
      decoded_cnt <= '0;
      illegal_cnt <= '0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (s1_adv) begin
          s1_valid <= in_valid;
          if (in_valid) s1_instr <= in_instr;
        end
        if (s2_adv) begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= dec;
            s2_raw  <= s1_instr;
          end
        end
      end
      // counts follow actual hand-offs, which a flush cannot undo
      if (s2_valid && out_ready) begin
        decoded_cnt <= decoded_cnt + CNT_ONE;
        if (s2_data.illegal) illegal_cnt <= illegal_cnt + CNT_ONE;
      end
    end
  end

  assign out_valid    = s2_valid;
  assign out_name     = s2_data.name;
  assign out_format   = s2_data.format;
  assign out_category = s2_data.category;
  assign out_rd       = s2_data.rd;
  assign out_rs1      = s2_data.rs1;
  assign out_rs2      = s2_data.rs2;
  assign out_imm      = s2_data.imm;
  assign out_csr      = s2_data.csr;
  assign out_illegal  = s2_data.illegal;
  assign out_raw      = s2_raw;

endmodule

// File: tb/tb_riscv_instr_decoder.sv
// tb/tb_riscv_instr_decoder.sv - directed self-checking bench for riscv_instr_decoder
module tb_riscv_instr_decoder;
  import riscv_instruction_properties::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                flush = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [31:0]         in_instr = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  riscv_instr_name_t   out_name;
  riscv_instr_format_t out_format;
  logic [15:0]         out_category;
  riscv_reg_t          out_rd, out_rs1, out_rs2;
  logic [31:0]         out_imm;
  logic [11:0]         out_csr;
  logic                out_illegal;
  logic [31:0]         out_raw;
  logic [31:0]         decoded_cnt, illegal_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  riscv_instr_decoder dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_name(out_name), .out_format(out_format), .out_category(out_category),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_csr(out_csr), .out_illegal(out_illegal), .out_raw(out_raw),
    .decoded_cnt(decoded_cnt), .illegal_cnt(illegal_cnt)
  );

  typedef struct {
    logic [31:0]         w;
    riscv_instr_name_t   nm;
    riscv_instr_format_t fmt;
    logic [15:0]         cat;
    riscv_reg_t          rd, rs1, rs2;
    logic [31:0]         imm;
    logic [11:0]         csr;
    logic                ill;
  } vec_t;

  // send one word with the output side open; lat = negedges from accept to out_valid
  task automatic drive_one(input logic [31:0] w, output int lat);
    @(posedge clk); #1;
    in_valid = 1'b1; in_instr = w; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (out_valid) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_cmp++; if (decoded_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_decoded_cnt got %0d want 0", decoded_cnt); end
    n_cmp++; if (illegal_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_illegal_cnt got %0d want 0", illegal_cnt); end
    n_cmp++; if (out_name !== LUI) begin n_bad++; $display("FAIL rst_name got %0d want 0", out_name); end
    n_cmp++; if (out_format !== J_FORMAT) begin n_bad++; $display("FAIL rst_format got %0d want 0", out_format); end
    n_cmp++; if (out_raw !== 32'd0) begin n_bad++; $display("FAIL rst_raw got %h want 0", out_raw); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_decode();
    vec_t v[13];
    int lat;
    logic [31:0] base_dec, base_ill;
    v[0]  = '{32'hFFF00293, ADDI,   I_FORMAT,       16'h0008, T0,   ZERO, ZERO, 32'hFFFFFFFF, 12'h000, 1'b0};
    v[1]  = '{32'h00000013, NOP,    I_FORMAT,       16'h0008, ZERO, ZERO, ZERO, 32'h00000000, 12'h000, 1'b0};
    v[2]  = '{32'h40315093, SRAI,   I_FORMAT_SHIFT, 16'h0004, RA,   SP,   ZERO, 32'h00000003, 12'h000, 1'b0};
    v[3]  = '{32'h20315093, NOP,    I_FORMAT,       16'h0000, ZERO, ZERO, ZERO, 32'h00000000, 12'h000, 1'b1};
    v[4]  = '{32'hFE208EE3, BEQ,    B_FORMAT,       16'h0040, ZERO, RA,   SP,   32'hFFFFFFFC, 12'h000, 1'b0};
    v[5]  = '{32'h30059573, CSRRW,  I_FORMAT,       16'h0800, A0,   A1,   ZERO, 32'h00000000, 12'h300, 1'b0};
    v[6]  = '{32'h123452B7, LUI,    U_FORMAT,       16'h0008, T0,   ZERO, ZERO, 32'h12345000, 12'h000, 1'b0};
    v[7]  = '{32'h40208033, SUB,    R_FORMAT,       16'h0008, ZERO, RA,   SP,   32'h00000000, 12'h000, 1'b0};
    v[8]  = '{32'h0020A223, SW,     S_FORMAT,       16'h0002, ZERO, RA,   SP,   32'h00000004, 12'h000, 1'b0};
    v[9]  = '{32'h00100073, EBREAK, I_FORMAT,       16'h2200, ZERO, ZERO, ZERO, 32'h00000000, 12'h000, 1'b0};
    v[10] = '{32'h3405D173, CSRRWI, I_FORMAT,       16'h0800, SP,   ZERO, ZERO, 32'h0000000B, 12'h340, 1'b0};
    v[11] = '{32'hFFFFFFFF, NOP,    I_FORMAT,       16'h0000, ZERO, ZERO, ZERO, 32'h00000000, 12'h000, 1'b1};
    v[12] = '{32'h008000EF, JAL,    J_FORMAT,       16'h0080, RA,   ZERO, ZERO, 32'h00000008, 12'h000, 1'b0};
    base_dec = decoded_cnt;
    base_ill = illegal_cnt;
    for (int k = 0; k < 13; k++) begin
      drive_one(v[k].w, lat);
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL latency[%0d] got %0d want 2", k, lat); end
      n_cmp++; if (out_name !== v[k].nm) begin n_bad++; $display("FAIL name[%h] got %s want %s", v[k].w, out_name.name(), v[k].nm.name()); end
      n_cmp++; if (out_format !== v[k].fmt) begin n_bad++; $display("FAIL format[%h] got %0d want %0d", v[k].w, out_format, v[k].fmt); end
      n_cmp++; if (out_category !== v[k].cat) begin n_bad++; $display("FAIL category[%h] got %h want %h", v[k].w, out_category, v[k].cat); end
      n_cmp++; if (out_rd !== v[k].rd) begin n_bad++; $display("FAIL rd[%h] got %0d want %0d", v[k].w, out_rd, v[k].rd); end
      n_cmp++; if (out_rs1 !== v[k].rs1) begin n_bad++; $display("FAIL rs1[%h] got %0d want %0d", v[k].w, out_rs1, v[k].rs1); end
      n_cmp++; if (out_rs2 !== v[k].rs2) begin n_bad++; $display("FAIL rs2[%h] got %0d want %0d", v[k].w, out_rs2, v[k].rs2); end
      n_cmp++; if (out_imm !== v[k].imm) begin n_bad++; $display("FAIL imm[%h] got %h want %h", v[k].w, out_imm, v[k].imm); end
      n_cmp++; if (out_csr !== v[k].csr) begin n_bad++; $display("FAIL csr[%h] got %h want %h", v[k].w, out_csr, v[k].csr); end
      n_cmp++; if (out_illegal !== v[k].ill) begin n_bad++; $display("FAIL illegal[%h] got %b want %b", v[k].w, out_illegal, v[k].ill); end
      n_cmp++; if (out_raw !== v[k].w) begin n_bad++; $display("FAIL raw got %h want %h", out_raw, v[k].w); end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (decoded_cnt !== base_dec + 32'd13) begin n_bad++; $display("FAIL decode_cnt got %0d want %0d", decoded_cnt, base_dec + 32'd13); end
    n_cmp++; if (illegal_cnt !== base_ill + 32'd2) begin n_bad++; $display("FAIL decode_ill_cnt got %0d want %0d", illegal_cnt, base_ill + 32'd2); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL decode_drained got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words[4];
    logic [31:0] base, held_raw;
    int sent, rcvd, hold;
    logic saw_stall, acc;
    words[0] = 32'h00100093; words[1] = 32'h00200113;
    words[2] = 32'h00300193; words[3] = 32'h00400213;
    base = decoded_cnt; sent = 0; rcvd = 0; hold = 0; saw_stall = 1'b0; held_raw = '0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_instr = words[0]; out_ready = 1'b0;
    for (int cyc = 0; cyc < 40 && rcvd < 4; cyc++) begin
      @(negedge clk);
      if (in_valid && !in_ready) saw_stall = 1'b1;
      if (out_valid && !out_ready) begin
        if (hold == 0) held_raw = out_raw;
        n_cmp++; if (out_raw !== words[0]) begin n_bad++; $display("FAIL b2b_hold[%0d] got %h want %h", hold, out_raw, words[0]); end
        hold++;
      end
      if (out_valid && out_ready) begin
        n_cmp++; if (out_raw !== words[rcvd]) begin n_bad++; $display("FAIL b2b_order[%0d] got %h want %h", rcvd, out_raw, words[rcvd]); end
        n_cmp++; if (out_name !== ADDI) begin n_bad++; $display("FAIL b2b_name[%0d] got %s want ADDI", rcvd, out_name.name()); end
        rcvd++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      in_valid = (sent < 4);
      if (sent < 4) in_instr = words[sent];
      out_ready = (hold >= 3);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (rcvd !== 4) begin n_bad++; $display("FAIL b2b_received got %0d want 4", rcvd); end
    n_cmp++; if (hold !== 3) begin n_bad++; $display("FAIL b2b_stall_cycles got %0d want 3", hold); end
    n_cmp++; if (saw_stall !== 1'b1) begin n_bad++; $display("FAIL b2b_backpressure got %b want 1", saw_stall); end
    @(negedge clk);
    n_cmp++; if (decoded_cnt !== base + 32'd4) begin n_bad++; $display("FAIL b2b_cnt got %0d want %0d", decoded_cnt, base + 32'd4); end
  endtask

  task automatic test_flush();
    logic [31:0] base_dec, base_ill;
    int lat;
    base_dec = decoded_cnt; base_ill = illegal_cnt;
    @(posedge clk); #1;
    in_valid = 1'b1; in_instr = 32'h00500293; out_ready = 1'b0;
    @(posedge clk); #1;
    in_instr = 32'h00600313;
    @(posedge clk); #1;
    in_instr = 32'h00700393; flush = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL flush_inflight got %b want 1", out_valid); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
    repeat (3) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_leftover got %b want 0", out_valid); end
    n_cmp++; if (decoded_cnt !== base_dec) begin n_bad++; $display("FAIL flush_dec_cnt got %0d want %0d", decoded_cnt, base_dec); end
    n_cmp++; if (illegal_cnt !== base_ill) begin n_bad++; $display("FAIL flush_ill_cnt got %0d want %0d", illegal_cnt, base_ill); end
    drive_one(32'h00800413, lat);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL post_flush_latency got %0d want 2", lat); end
    n_cmp++; if (out_raw !== 32'h00800413) begin n_bad++; $display("FAIL post_flush_raw got %h want 00800413", out_raw); end
    n_cmp++; if (out_rd !== S0) begin n_bad++; $display("FAIL post_flush_rd got %0d want 8", out_rd); end
  endtask

  task automatic test_async_reset();
    logic [31:0] words[5];
    int lat;
    words[0] = 32'h00100093; words[1] = 32'h20315093; words[2] = 32'h00000013;
    words[3] = 32'hFE208EE3; words[4] = 32'h30059573;
    @(posedge clk); #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) drive_one(words[k], lat);
    @(posedge clk); #1;
    in_valid = 1'b1; in_instr = 32'h00900493; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL pre_rst_out_valid got %b want 1", out_valid); end
    n_cmp++; if (decoded_cnt !== 32'd5) begin n_bad++; $display("FAIL pre_rst_dec_cnt got %0d want 5", decoded_cnt); end
    n_cmp++; if (illegal_cnt !== 32'd1) begin n_bad++; $display("FAIL pre_rst_ill_cnt got %0d want 1", illegal_cnt); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL async_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL async_in_ready got %b want 0", in_ready); end
    n_cmp++; if (decoded_cnt !== 32'd0) begin n_bad++; $display("FAIL async_dec_cnt got %0d want 0", decoded_cnt); end
    n_cmp++; if (illegal_cnt !== 32'd0) begin n_bad++; $display("FAIL async_ill_cnt got %0d want 0", illegal_cnt); end
    n_cmp++; if (out_name !== LUI) begin n_bad++; $display("FAIL async_name got %0d want 0", out_name); end
    @(posedge clk); #1 rst_n = 1'b1;
    drive_one(32'hFFFFFFFF, lat);
    n_cmp++; if (out_illegal !== 1'b1) begin n_bad++; $display("FAIL post_rst_illegal got %b want 1", out_illegal); end
    n_cmp++; if (out_name !== NOP) begin n_bad++; $display("FAIL post_rst_name got %s want NOP", out_name.name()); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (illegal_cnt !== 32'd1) begin n_bad++; $display("FAIL post_rst_ill_cnt got %0d want 1", illegal_cnt); end
    n_cmp++; if (decoded_cnt !== 32'd1) begin n_bad++; $display("FAIL post_rst_dec_cnt got %0d want 1", decoded_cnt); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
